// File: rtl/sakebi_rmii_tx.sv
// sakebi_rmii_tx: AXI4-Stream byte slave to RMII transmit dibits.
// Each frame gets a preamble and SFD, short frames are zero padded, an
// optional CRC-32 FCS is appended, and an inter-packet gap is enforced.
// The clock is the 50 MHz RMII REF_CLK, so TXD launches straight off it.
module sakebi_rmii_tx #(
  parameter int P_MIN_FRAME  = 60,
  parameter int P_APPEND_FCS = 1,
  parameter int P_IFG_BYTES  = 12
) (
  input  logic       i_axis_ACLK,
  input  logic       i_axis_ARESETn,
  input  logic       i_axis_TVALID,
  output logic       o_axis_TREADY,
  input  logic [7:0] i_axis_TDATA,
  input  logic       i_axis_TLAST,
  output logic       o_rmii_TX_EN,
  output logic [1:0] o_rmii_TXD,
  output logic       o_tx_busy,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG,
    S_DRAIN
  } state_t;

  localparam logic [10:0] MIN_FRAME = 11'(P_MIN_FRAME);
  localparam int          IFG_CYC   = P_IFG_BYTES * 4;
  // The IDLE cycle that follows IFG is itself a TX_EN-low cycle, so the IFG
  // state lasts one cycle less than the gap; a waiting frame then starts its
  // preamble exactly IFG_CYC low cycles after the previous frame.
  localparam logic [15:0] IFG_LAST  = (IFG_CYC >= 2) ? 16'(IFG_CYC - 2) : 16'd0;
  localparam logic [15:0] PRE_LAST  = 16'd27;
  localparam logic [15:0] FCS_LAST  = 16'd15;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;            // dibit index within the current state
  logic [31:0] shift_q, shift_d;        // dibits still to send, LSB dibit next
  logic        last_q, last_d;          // byte in flight carried TLAST
  logic [10:0] byte_cnt_q, byte_cnt_d;  // payload + pad bytes, saturating
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d;
  logic [1:0]  txd_q, txd_d;

  logic        tready;
  logic        underrun;
  logic        take_byte;
  logic        end_body;
  logic        goto_ifg;
  logic [11:0] cnt_diff;
  logic        pad_needed;
  logic [10:0] byte_cnt_inc;

  // Reflected CRC-32 (poly 0x04C11DB7, reversed form 0xEDB88320), one byte.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Sign of (bytes so far - minimum) decides whether padding is still owed;
  // done as a subtraction so a zero minimum simply never pads.
  assign cnt_diff     = {1'b0, byte_cnt_q} - {1'b0, MIN_FRAME};
  assign pad_needed   = cnt_diff[11];
  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

  // Next-state, datapath and registered-output selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    shift_d    = shift_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    tready     = 1'b0;
    underrun   = 1'b0;
    take_byte  = 1'b0;
    end_body   = 1'b0;
    goto_ifg   = 1'b0;
    tx_en_d    = 1'b0;
    txd_d      = 2'b00;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A waiting byte starts the frame but is not consumed here.
        if (i_axis_TVALID) begin
          state_d    = S_PREAMBLE;
          crc_d      = 32'hFFFFFFFF;
          byte_cnt_d = '0;
          last_d     = 1'b0;
        end
      end
      S_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_SFD;
          cnt_d   = '0;
        end
      end
      S_SFD: begin
        if (cnt_q[1:0] == 2'd3) begin
          tready = 1'b1;
          if (i_axis_TVALID) take_byte = 1'b1;
          else               underrun  = 1'b1;
        end
      end
      S_DATA: begin
        shift_d = shift_q >> 2;
        if (cnt_q[1:0] == 2'd3) begin
          if (last_q) begin
            end_body = 1'b1;
          end else begin
            tready = 1'b1;
            if (i_axis_TVALID) take_byte = 1'b1;
            else               underrun  = 1'b1;
          end
        end
      end
      S_PAD: begin
        shift_d = shift_q >> 2;
        if (cnt_q[1:0] == 2'd3) end_body = 1'b1;
      end
      S_FCS: begin
        shift_d = shift_q >> 2;
        if (cnt_q == FCS_LAST) goto_ifg = 1'b1;
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        // Swallow the rest of the aborted packet up to its TLAST beat.
        tready = 1'b1;
        if (i_axis_TVALID && i_axis_TLAST) goto_ifg = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (underrun) begin
      state_d = S_DRAIN;
      cnt_d   = '0;
    end

    // Accepted byte goes straight into the shifter: no bubble between bytes.
    if (take_byte) begin
      state_d    = S_DATA;
      cnt_d      = '0;
      shift_d    = {24'h000000, i_axis_TDATA};
      last_d     = i_axis_TLAST;
      byte_cnt_d = byte_cnt_inc;
      crc_d      = crc_byte(crc_q, i_axis_TDATA);
    end

    // Payload (or a pad byte) finished: more padding, FCS, or gap.
    if (end_body) begin
      if (pad_needed) begin
        state_d    = S_PAD;
        cnt_d      = '0;
        shift_d    = '0;
        byte_cnt_d = byte_cnt_inc;
        crc_d      = crc_byte(crc_q, 8'h00);
      end else if (P_APPEND_FCS != 0) begin
        state_d = S_FCS;
        cnt_d   = '0;
        shift_d = ~crc_q;
      end else begin
        goto_ifg = 1'b1;
      end
    end

    if (goto_ifg) begin
      cnt_d   = '0;
      state_d = (IFG_CYC >= 2) ? S_IFG : S_IDLE;
    end

    // Outputs are registered, so they follow the state being entered.
    case (state_d)
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = 2'b01;
      end
      S_SFD: begin
        tx_en_d = 1'b1;
        txd_d   = (cnt_d[1:0] == 2'd3) ? 2'b11 : 2'b01;
      end
      S_DATA, S_PAD, S_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = shift_d[1:0];
      end
      default: begin
        tx_en_d = 1'b0;
        txd_d   = 2'b00;
      end
    endcase
  end

  // State, datapath and RMII output registers; reset drops TX_EN at once.
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
      crc_q      <= '0;
      tx_en_q    <= 1'b0;
      txd_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
    end
  end

  assign o_axis_TREADY = tready;
  assign o_underrun    = underrun;
  assign o_tx_busy     = (state_q != S_IDLE);
  assign o_rmii_TX_EN  = tx_en_q;
  assign o_rmii_TXD    = txd_q;

endmodule

// File: tb/tb_sakebi_rmii_tx.sv
// Scoreboard bench for sakebi_rmii_tx: stimulus pushes expected frame dibits,
// a negedge monitor collects each TX_EN burst and compares it.
module tb_sakebi_rmii_tx;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       sel = 1'b0;  // 0: default-parameter DUT, 1: no-padding DUT

  logic       tv0, tv1, tr0, tr1, en0, en1, b0, b1, u0, u1;
  logic [1:0] txd0, txd1;

  always #10 clk = ~clk;

  assign tv0 = tvalid & ~sel;
  assign tv1 = tvalid & sel;

  sakebi_rmii_tx dut (
    .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
    .i_axis_TVALID(tv0), .o_axis_TREADY(tr0),
    .i_axis_TDATA(tdata), .i_axis_TLAST(tlast),
    .o_rmii_TX_EN(en0), .o_rmii_TXD(txd0),
    .o_tx_busy(b0), .o_underrun(u0)
  );

  sakebi_rmii_tx #(.P_MIN_FRAME(0)) dut_nopad (
    .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
    .i_axis_TVALID(tv1), .o_axis_TREADY(tr1),
    .i_axis_TDATA(tdata), .i_axis_TLAST(tlast),
    .o_rmii_TX_EN(en1), .o_rmii_TXD(txd1),
    .o_tx_busy(b1), .o_underrun(u1)
  );

  // Only one DUT is active at a time; the idle one must drive zeros.
  logic       tx_en, tready_m, busy_m, underrun_m;
  logic [1:0] txd;
  assign tx_en      = en0 | en1;
  assign txd        = txd0 | txd1;
  assign underrun_m = u0 | u1;
  assign tready_m   = sel ? tr1 : tr0;
  assign busy_m     = sel ? b1 : b0;

  int n_cmp = 0;
  int n_bad = 0;
  int frame_no = 0;
  int underrun_cnt = 0;
  int tready_cnt = 0;
  int idle_txd_bad = 0;
  int low_run = 0;
  bit in_frame = 0;
  bit seen_fall = 0;
  bit prev_en = 0;

  logic [1:0] exp_dib[$];
  int         exp_len[$];
  logic [1:0] got_q[$];
  int         gap_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference FCS: bitwise reflected CRC-32 over the frame body.
  function automatic logic [31:0] fcs32(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected wire image: 7x 0x55, 0xD5, then body; 4 dibits per byte, LSB first.
  task automatic expect_bytes(input bq_t body);
    bq_t all;
    for (int i = 0; i < 7; i++) all.push_back(8'h55);
    all.push_back(8'hD5);
    foreach (body[i]) all.push_back(body[i]);
    foreach (all[i]) for (int k = 0; k < 4; k++) exp_dib.push_back(2'((all[i] >> (2 * k)) & 8'h03));
    exp_len.push_back(all.size() * 4);
  endtask

  task automatic expect_frame(input bq_t payload, input int min_frame);
    bq_t body;
    logic [31:0] f;
    body = payload;
    while (body.size() < min_frame) body.push_back(8'h00);
    f = fcs32(body);
    for (int k = 0; k < 4; k++) body.push_back(f[8*k +: 8]);
    expect_bytes(body);
  endtask

  task automatic check_frame();
    int L, bad_idx;
    logic [1:0] e, g_at, e_at;
    frame_no++;
    chk("frame_expected", exp_len.size() > 0, 1);
    if (exp_len.size() == 0) begin
      got_q.delete();
      return;
    end
    L = exp_len.pop_front();
    chk("frame_len", got_q.size(), L);
    bad_idx = -1;
    g_at = 2'b00;
    e_at = 2'b00;
    for (int i = 0; i < L; i++) begin
      e = exp_dib.pop_front();
      if (bad_idx < 0 && (i >= got_q.size() || got_q[i] !== e)) begin
        bad_idx = i;
        e_at = e;
        g_at = (i < got_q.size()) ? got_q[i] : 2'bxx;
      end
    end
    n_cmp++;
    if (bad_idx >= 0) begin
      n_bad++;
      $display("FAIL frame_data: frame %0d dibit %0d got %b required %b", frame_no, bad_idx, g_at, e_at);
    end else begin
      $display("frame %0d: %0d dibits on the wire, %0d expected", frame_no, got_q.size(), L);
    end
    got_q.delete();
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      got_q.delete();
      in_frame = 0;
      seen_fall = 0;
      low_run = 0;
      prev_en = 0;
    end else begin
      if (tx_en) begin
        if (!prev_en && seen_fall) gap_q.push_back(low_run);
        got_q.push_back(txd);
        in_frame = 1;
      end else begin
        if (txd != 2'b00) idle_txd_bad++;
        if (in_frame) begin
          check_frame();
          in_frame = 0;
          seen_fall = 1;
          low_run = 0;
        end
        low_run++;
      end
      if (underrun_m) underrun_cnt++;
      if (tready_m) tready_cnt++;
      prev_en = tx_en;
    end
  end

  task automatic push_byte(input logic [7:0] d, input logic last);
    int t;
    tvalid = 1'b1;
    tdata = d;
    tlast = last;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tready_m && t < 3000);
    chk("push_ready", tready_m, 1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic send_frame(input bq_t p);
    foreach (p[i]) push_byte(p[i], i == p.size() - 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy_m && t < 6000);
    chk("busy_clears", busy_m, 0);
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p, q;
    int t, u0c, tr0c;

    // Reset state.
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_en", en0, 0);
    chk("rst_txd", txd0, 0);
    chk("rst_tready", tr0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_underrun", u0, 0);

    // "123456789" without padding: FCS bytes 26 39 F4 CB.
    sel = 1'b1;
    p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    q = p;
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
    expect_bytes(q);
    send_frame(p);
    wait_idle();

    // Single byte, default padding; TREADY asserted once.
    sel = 1'b0;
    tr0c = tready_cnt;
    p = {8'hAA};
    expect_frame(p, 60);
    send_frame(p);
    wait_idle();
    chk("tready_once", tready_cnt - tr0c, 1);

    // 64 bytes sustained: no padding, one TREADY per byte.
    p.delete();
    for (int i = 0; i < 64; i++) p.push_back(8'($urandom));
    tr0c = tready_cnt;
    expect_frame(p, 60);
    send_frame(p);
    wait_idle();
    chk("tready_64", tready_cnt - tr0c, 64);

    // Underrun after 10 of 20 bytes.
    p.delete();
    for (int i = 0; i < 20; i++) p.push_back(8'($urandom));
    q = p[0:9];
    expect_bytes(q);
    u0c = underrun_cnt;
    for (int i = 0; i < 10; i++) push_byte(p[i], 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tready_m && t < 100);
    chk("underrun_window", tready_m, 1);
    @(posedge clk);
    #1;
    for (int i = 10; i < 20; i++) push_byte(p[i], i == 19);
    wait_idle();
    chk("underrun_pulse", underrun_cnt - u0c, 1);
    p.delete();
    for (int i = 0; i < 30; i++) p.push_back(8'($urandom));
    expect_frame(p, 60);
    send_frame(p);
    wait_idle();

    // Back-to-back: second frame waits through the gap with TVALID high.
    p.delete();
    for (int i = 0; i < 5; i++) p.push_back(8'($urandom));
    q.delete();
    for (int i = 0; i < 70; i++) q.push_back(8'($urandom));
    expect_frame(p, 60);
    expect_frame(q, 60);
    send_frame(p);
    send_frame(q);
    wait_idle();
    chk("gap_seen", gap_q.size() > 0, 1);
    if (gap_q.size() > 0) chk("gap_48", gap_q[$], 48);

    // Reset in the middle of DATA.
    for (int i = 0; i < 5; i++) push_byte(8'($urandom), 1'b0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx_en", en0, 0);
    chk("arst_txd", txd0, 0);
    chk("arst_tready", tr0, 0);
    chk("arst_busy", b0, 0);
    tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    p.delete();
    for (int i = 0; i < 12; i++) p.push_back(8'($urandom));
    expect_frame(p, 60);
    send_frame(p);
    wait_idle();

    // Randomized frames on either DUT.
    for (int n = 0; n < 10; n++) begin
      sel = 1'($urandom_range(0, 1));
      p.delete();
      t = $urandom_range(1, 90);
      for (int i = 0; i < t; i++) p.push_back(8'($urandom));
      expect_frame(p, sel ? 0 : 60);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
      send_frame(p);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("all_frames_seen", exp_len.size(), 0);
    chk("underrun_total", underrun_cnt, 1);
    chk("idle_txd_zero", idle_txd_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
